// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline hazard controller for a classic 5-stage in-order pipeline.
// It detects load-use hazards in ID, flushes on taken branches resolved in EX,
// and holds the front end while a multi-cycle multiply/divide occupies EX.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// stall-cycle counter. Without it, stall_cycles is tied to zero and
// no counter flops exist.
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 8          // EX occupancy of mul/div, 2..15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic        branch_taken,
    input  logic        md_start,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);

    // The RUN cycle that accepts md_start is the first stall cycle; the
    // MD_BUSY state then counts down to zero inclusive, which gives
    // MD_LATENCY stall cycles in total.
    localparam logic [3:0] MD_CNT_INIT = 4'(MD_LATENCY - 2);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MD_BUSY    = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_md_cnt;
    logic       w_load_use;
    logic       w_cnt_load;
    logic       w_cnt_dec;

    // A load writing r0 never creates a real dependency, so it is excluded.
    assign w_load_use = idex_memread && (idex_rt != 5'd0) &&
                        ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

    // State register; reset drops any in-flight stall without completing it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; priority in RUN is branch, then mul/div, then load-use.
    always_comb begin
        w_next_state = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (branch_taken) begin
                    w_next_state = ST_RUN;
                end else if (md_start) begin
                    w_next_state = ST_MD_BUSY;
                    w_cnt_load   = 1'b1;
                end else if (w_load_use) begin
                    w_next_state = ST_LOAD_STALL;
                end
            end
            ST_LOAD_STALL: begin
                // The dependent instruction now sees the loaded value via
                // forwarding, so one bubble is always enough.
                w_next_state = ST_RUN;
            end
            ST_MD_BUSY: begin
                if (r_md_cnt == 4'd0) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // Output decode from current state and inputs.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (branch_taken) begin
                    // Squash the two younger instructions; fetch redirects.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (md_start) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    md_busy     = 1'b1;
                end else if (w_load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            ST_LOAD_STALL: begin
                // A branch can still resolve in EX while the bubble drains.
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
            end
            ST_MD_BUSY: begin
                // EX is owned by the mul/div unit; branch and md_start
                // cannot originate from EX while it is occupied.
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                md_busy     = 1'b1;
                md_done     = (r_md_cnt == 4'd0);
            end
            default: begin
                pc_write    = 1'b1;
            end
        endcase
    end

    // Mul/div occupancy counter; only decremented while non-zero so it never wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_md_cnt <= 4'd0;
        end else if (w_cnt_load) begin
            r_md_cnt <= MD_CNT_INIT;
        end else if (w_cnt_dec && (r_md_cnt != 4'd0)) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_cycles;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= 16'h0000;
        end else if (!pc_write && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl: a vector table for single-cycle
// RUN-state decisions plus hand-written multi-cycle sequences.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 8;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [15:0] EXP_ONE  = 16'd1;
    localparam logic [15:0] EXP_LAT  = 16'(LAT);
    localparam logic [15:0] EXP_SAT  = 16'hFFFF;
`else
    localparam logic [15:0] EXP_ONE  = 16'h0000;
    localparam logic [15:0] EXP_LAT  = 16'h0000;
    localparam logic [15:0] EXP_SAT  = 16'h0000;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic        branch_taken;
    logic        md_start;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        md_busy;
    logic        md_done;
    logic [15:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.MD_LATENCY(LAT)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .stall_cycles (stall_cycles)
    );

    // {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done}
    logic [5:0] w_out;
    assign w_out = {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done};

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       md;
        logic [5:0] exp_out;   // outputs in the applied cycle
        logic [1:0] exp_next;  // {pc_write, md_busy} next cycle, br/md cleared
    } vec_t;

    vec_t tv[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        id_uses_rt   = 1'b0;
        idex_memread = 1'b0;
        idex_rt      = 5'd0;
        branch_taken = 1'b0;
        md_start     = 1'b0;
    endtask

    // Called just after a falling edge: async reset pulse that lands well
    // before the next rising edge.
    task automatic pulse_reset();
        clear_inputs();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_load_use_rs5();
        idex_memread = 1'b1;
        idex_rt      = 5'd5;
        id_rs        = 5'd5;
    endtask

    initial begin
        int nb;
        int np;
        int nd;
        int nf;
        int done_at;

        // rs rt ur mr exrt br md  out        next
        tv[0]  = '{5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 6'b110000, 2'b10}; // idle
        tv[1]  = '{5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 6'b000100, 2'b10}; // load-use rs
        tv[2]  = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 6'b110000, 2'b10}; // r0 load
        tv[3]  = '{5'd3,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 6'b000100, 2'b10}; // load-use rt
        tv[4]  = '{5'd3,  5'd7,  1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 6'b110000, 2'b10}; // rt not read
        tv[5]  = '{5'd9,  5'd0,  1'b0, 1'b0, 5'd9,  1'b0, 1'b0, 6'b110000, 2'b10}; // not a load
        tv[6]  = '{5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 6'b000110, 2'b01}; // mul/div
        tv[7]  = '{5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 6'b111100, 2'b10}; // branch
        tv[8]  = '{5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 6'b111100, 2'b00}; // all three
        tv[9]  = '{5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b0, 1'b1, 6'b000110, 2'b01}; // md > load
        tv[10] = '{5'd0,  5'd31, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 6'b000100, 2'b10}; // rt=31

        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("reset_outputs", 32'(w_out), 32'(6'b110000));
        check("reset_stall_cnt", 32'(stall_cycles), 32'h0);
        reset_n = 1'b1;

        // Vector table: each applied from a fresh RUN state.
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            pulse_reset();
            id_rs        = tv[i].rs;
            id_rt        = tv[i].rt;
            id_uses_rt   = tv[i].uses_rt;
            idex_memread = tv[i].memread;
            idex_rt      = tv[i].ex_rt;
            branch_taken = tv[i].br;
            md_start     = tv[i].md;
            #1;
            check($sformatf("vec%0d_out", i), 32'(w_out), 32'(tv[i].exp_out));
            @(negedge clock);
            branch_taken = 1'b0;
            md_start     = 1'b0;
            #1;
            check($sformatf("vec%0d_next", i), 32'({pc_write, md_busy}), 32'(tv[i].exp_next));
        end

        // Single load-use stall followed by defaults, one stall counted.
        @(negedge clock);
        pulse_reset();
        set_load_use_rs5();
        #1;
        check("lu_stall", 32'(w_out), 32'(6'b000100));
        @(negedge clock);
        #1;
        check("lu_release", 32'(w_out), 32'(6'b110000));
        clear_inputs();
        @(negedge clock);
        #1;
        check("lu_stall_cnt", 32'(stall_cycles), 32'(EXP_ONE));

        // Branch resolving while in LOAD_STALL, then RUN re-evaluates load-use.
        @(negedge clock);
        pulse_reset();
        set_load_use_rs5();
        @(negedge clock);
        branch_taken = 1'b1;
        #1;
        check("ls_branch", 32'(w_out), 32'(6'b111100));
        @(negedge clock);
        branch_taken = 1'b0;
        #1;
        check("ls_back_to_run", 32'(w_out), 32'(6'b000100));

        // Full mul/div occupancy; branch and md_start in MD_BUSY are ignored.
        @(negedge clock);
        pulse_reset();
        nb = 0; np = 0; nd = 0; nf = 0; done_at = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clock);
            if (c > 1) #1;
            branch_taken = (c == 3);
            md_start     = (c == 1) || (c == 4);
            #1;
            if (md_busy) nb++;
            if (!pc_write) np++;
            if (ifid_flush) nf++;
            if (md_done) begin
                nd++;
                done_at = c;
            end
        end
        clear_inputs();
        check("md_busy_cycles", 32'(nb), 32'(LAT));
        check("md_pcw_low_cycles", 32'(np), 32'(LAT));
        check("md_done_count", 32'(nd), 32'd1);
        check("md_done_cycle", 32'(done_at), 32'(LAT));
        check("md_branch_ignored", 32'(nf), 32'd0);
        check("md_stall_cnt", 32'(stall_cycles), 32'(EXP_LAT));

        // Reset three cycles into MD_BUSY aborts with no completion pulse.
        @(negedge clock);
        pulse_reset();
        md_start = 1'b1;
        @(negedge clock);
        md_start = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("abort_busy_before", 32'(md_busy), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy_now", 32'(md_busy), 32'd0);
        check("abort_stall_cnt", 32'(stall_cycles), 32'h0);
        nd = 0;
        nb = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (c == 3) reset_n = 1'b1;
            #1;
            if (md_done) nd++;
            if (md_busy) nb++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        check("abort_no_busy", 32'(nb), 32'd0);

        // Saturation of the stall counter under a continuous mul/div stream.
        @(negedge clock);
        pulse_reset();
        md_start = 1'b1;
        repeat (65540) @(negedge clock);
        #1;
        check("sat_stall_cnt", 32'(stall_cycles), 32'(EXP_SAT));
        md_start = 1'b0;
        repeat (12) @(negedge clock);
        #1;
        check("sat_stall_hold", 32'(stall_cycles), 32'(EXP_SAT));
        reset_n = 1'b0;
        #1;
        check("sat_reset_clear", 32'(stall_cycles), 32'h0);
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
